// File: rtl/inversion.sv
// inversion: modular inverse a^-1 mod p (p = 2^255-19) by binary extended Euclid,
// one iteration per cycle, single-cycle valid pulse on completion.
module inversion #(
  parameter int WIDTH = 255,
  parameter logic [WIDTH-1:0] MODULUS = {WIDTH{1'b1}} - WIDTH'(18)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic             i_first,
  output logic [WIDTH-1:0] o_inv_a,
  output logic             o_out_valid
);
  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0] P = {1'b0, MODULUS};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [W1-1:0] u, v, x1, x2, u_nx, v_nx, x1_nx, x2_nx;
  logic [WIDTH-1:0] a_n;
  logic start, u_one, v_one;
  function automatic logic [W1-1:0] half(input logic [W1-1:0] x);
    return x[0] ? (x + P) >> 1 : x >> 1;
  endfunction
  function automatic logic [W1-1:0] subm(input logic [W1-1:0] x, input logic [W1-1:0] y);
    return x >= y ? x - y : x - y + P;
  endfunction
  assign a_n = i_in_a >= MODULUS ? i_in_a - MODULUS : i_in_a;
  assign start = state == IDLE && i_first;
  assign u_one = u == W1'(1);
  assign v_one = v == W1'(1);
  always_comb begin
    state_nx = state;
    if (start) state_nx = a_n == '0 ? DONE : RUN;
    else if (state == RUN && (u_one || v_one)) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // Invariant: x1*a == u and x2*a == v (mod p). The difference of two odd values is
  // even, so each subtraction is halved in the same step to bound the iteration count.
  always_comb begin
    u_nx = u;
    v_nx = v;
    x1_nx = x1;
    x2_nx = x2;
    if (start) begin
      u_nx = {1'b0, a_n};
      v_nx = P;
      x1_nx = a_n == '0 ? '0 : W1'(1);
      x2_nx = '0;
    end else if (state == RUN) begin
      if (u_one) x1_nx = x1;
      else if (v_one) x1_nx = x2;
      else if (!u[0]) begin
        u_nx = u >> 1;
        x1_nx = half(x1);
      end else if (!v[0]) begin
        v_nx = v >> 1;
        x2_nx = half(x2);
      end else if (u >= v) begin
        u_nx = (u - v) >> 1;
        x1_nx = half(subm(x1, x2));
      end else begin
        v_nx = (v - u) >> 1;
        x2_nx = half(subm(x2, x1));
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      u <= '0;
      v <= '0;
      x1 <= '0;
      x2 <= '0;
      o_inv_a <= '0;
      o_out_valid <= 1'b0;
    end else begin
      state <= state_nx;
      u <= u_nx;
      v <= v_nx;
      x1 <= x1_nx;
      x2 <= x2_nx;
      o_out_valid <= state == DONE;
      if (state == DONE) o_inv_a <= x1[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_inversion.sv
// tb_inversion: directed plus random checks of inversion against a Fermat-exponentiation model.
module tb_inversion;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_first = 1'b0;
  logic [254:0] i_in_a = '0;
  logic [254:0] o_inv_a;
  logic o_out_valid;
  int checks = 0;
  int failures = 0;
  inversion dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_in_a(i_in_a),
    .i_first(i_first),
    .o_inv_a(o_inv_a),
    .o_out_valid(o_out_valid)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] r;
    r = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
    return r[255:0];
  endfunction
  // a^(p-2) mod p; maps 0 (and p) to 0
  function automatic logic [255:0] inv_model(input logic [255:0] a);
    logic [255:0] b, r, e;
    b = a % P;
    r = 256'd1;
    e = P - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction
  function automatic logic [255:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [255:0] rnd_field();
    return rnd() % (P - 256'd1) + 256'd1;
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [255:0] a, input logic [255:0] exp,
                     input bit noise, output int lat);
    bit seen;
    logic [255:0] r;
    @(negedge i_clk);
    chk({tag, "_idle_valid"}, {255'd0, o_out_valid}, 256'd0);
    i_first = 1'b1;
    i_in_a = a[254:0];
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 600) begin
      @(negedge i_clk);
      lat++;
      seen = o_out_valid;
      i_first = noise && !seen && (lat % 3 == 1);
      r = rnd();
      i_in_a = i_first ? r[254:0] : a[254:0];
    end
    i_first = 1'b0;
    chk({tag, "_seen"}, {255'd0, seen}, 256'd1);
    chk({tag, "_lat_bound"}, {255'd0, lat <= 514}, 256'd1);
    chk({tag, "_result"}, {1'b0, o_inv_a}, exp);
  endtask
  initial begin
    int lat, lat2;
    logic [255:0] a;
    bit stale;
    repeat (3) @(negedge i_clk);
    chk("reset_valid", {255'd0, o_out_valid}, 256'd0);
    chk("reset_inv", {1'b0, o_inv_a}, 256'd0);
    i_rst_n = 1'b1;
    run("one", 256'd1, 256'd1, 1'b0, lat);
    chk("one_lat", 256'(lat), 256'd3);
    run("two", 256'd2, (P + 256'd1) >> 1, 1'b0, lat);
    run("pm1", P - 256'd1, P - 256'd1, 1'b0, lat);
    run("zero", 256'd0, 256'd0, 1'b0, lat);
    chk("zero_lat", 256'(lat), 256'd2);
    run("eq_p", P, 256'd0, 1'b0, lat);
    chk("eq_p_lat", 256'(lat), 256'd2);
    for (int i = 0; i < 100; i++) begin
      a = rnd_field();
      run("rand", a, inv_model(a), 1'b0, lat);
      chk("rand_prod", mulmod(a, {1'b0, o_inv_a}), 256'd1);
    end
    a = rnd_field();
    run("det_a", a, inv_model(a), 1'b0, lat);
    run("det_mid", 256'd3, inv_model(256'd3), 1'b0, lat2);
    run("det_b", a, inv_model(a), 1'b0, lat2);
    chk("det_lat", 256'(lat2), 256'(lat));
    for (int i = 0; i < 3; i++) begin
      a = rnd_field();
      run("noise", a, inv_model(a), 1'b1, lat);
    end
    @(negedge i_clk);
    a = rnd_field();
    i_first = 1'b1;
    i_in_a = a[254:0];
    @(negedge i_clk);
    i_first = 1'b0;
    repeat (50) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {255'd0, o_out_valid}, 256'd0);
    chk("async_rst_inv", {1'b0, o_inv_a}, 256'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    stale = 1'b0;
    repeat (600) begin
      @(negedge i_clk);
      if (o_out_valid) stale = 1'b1;
    end
    chk("no_stale_valid", {255'd0, stale}, 256'd0);
    run("after_rst", a, inv_model(a), 1'b0, lat);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
